// File: rtl/exc_flush_ctrl.sv
// Precise exception / ERET sequencer: stall, drain dmem, one CP0 update, then flush and redirect fetch.
// IDLE -> (DRAIN) -> COMMIT -> FLUSH -> IDLE; strobes are decoded from state so each is exactly one cycle.
module exc_flush_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] exc_type_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_slot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        dmem_busy_i,
    input  logic        if_ready_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        cp0_we_o,
    output logic        cp0_epc_we_o,
    output logic [4:0]  cp0_exc_code_o,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_bd_o,
    output logic        cp0_set_exl_o,
    output logic        cp0_clr_exl_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W    = 2;
    localparam int unsigned STATUS_EXL = 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_COMMIT = 2'd2,
        S_FLUSH  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        exc_code_q, exc_code_d;
    logic              eret_q, eret_d;
    logic [31:0]       pc_q, pc_d;
    logic              bd_q, bd_d;
    logic [31:0]       target_q, target_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              acc_c;
    logic              eret_c;
    logic [4:0]        code_c;

    // Only EXL is consulted from Status.
    logic unused_status;
    assign unused_status = ^{cp0_status_i[31:2], cp0_status_i[0]};

    // Decode the mem-stage code into accept / ERET / Cause.ExcCode.
    always_comb begin
        acc_c  = 1'b1;
        eret_c = 1'b0;
        code_c = 5'd0;
        case (exc_type_i)
            32'h0000_0001: code_c = 5'd0;
            32'h0000_0008: code_c = 5'd8;
            32'h0000_0009: code_c = 5'd9;
            32'h0000_000a: code_c = 5'd10;
            32'h0000_000c: code_c = 5'd12;
            32'h0000_000d: code_c = 5'd13;
            32'h0000_000e: eret_c = 1'b1;
            default:       acc_c  = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            exc_code_q <= 5'd0;
            eret_q     <= 1'b0;
            pc_q       <= 32'd0;
            bd_q       <= 1'b0;
            target_q   <= 32'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            exc_code_q <= exc_code_d;
            eret_q     <= eret_d;
            pc_q       <= pc_d;
            bd_q       <= bd_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        exc_code_d     = exc_code_q;
        eret_d         = eret_q;
        pc_d           = pc_q;
        bd_d           = bd_q;
        target_d       = target_q;
        cnt_d          = cnt_q;
        stall_o        = 1'b0;
        flush_o        = 1'b0;
        new_pc_o       = 32'd0;
        cp0_we_o       = 1'b0;
        cp0_epc_we_o   = 1'b0;
        cp0_exc_code_o = 5'd0;
        cp0_epc_o      = 32'd0;
        cp0_bd_o       = 1'b0;
        cp0_set_exl_o  = 1'b0;
        cp0_clr_exl_o  = 1'b0;
        busy_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acc_c) begin
                    stall_o    = 1'b1;
                    exc_code_d = code_c;
                    eret_d     = eret_c;
                    pc_d       = mem_pc_i;
                    bd_d       = mem_in_delay_slot_i;
                    state_d    = dmem_busy_i ? S_DRAIN : S_COMMIT;
                end
            end
            S_DRAIN: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                if (!dmem_busy_i) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                cnt_d   = CNT_LOAD;
                state_d = S_FLUSH;
                if (eret_q) begin
                    cp0_clr_exl_o = 1'b1;
                    target_d      = cp0_epc_i;
                end else begin
                    cp0_we_o       = 1'b1;
                    cp0_exc_code_o = exc_code_q;
                    cp0_bd_o       = bd_q;
                    cp0_set_exl_o  = 1'b1;
                    target_d       = EXC_VECTOR;
                    // Nested exception (EXL already set) keeps the original EPC.
                    if (!cp0_status_i[STATUS_EXL]) begin
                        cp0_epc_we_o = 1'b1;
                        cp0_epc_o    = bd_q ? (pc_q - 32'd4) : pc_q;
                    end
                end
            end
            S_FLUSH: begin
                flush_o  = 1'b1;
                busy_o   = 1'b1;
                new_pc_o = target_q;
                if (cnt_q == '0) begin
                    if (if_ready_i) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed cycle-by-cycle vectors for exc_flush_ctrl; a second instance covers a 3-cycle flush.
module tb_exc_flush_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    typedef struct packed {
        logic        rst;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] status;
        logic [31:0] epc;
        logic        dbusy;
        logic        rdy;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        we;
        logic        epc_we;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        set;
        logic        clr;
        logic        busy;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] exc_type_i, mem_pc_i, cp0_status_i, cp0_epc_i;
    logic        mem_in_delay_slot_i, dmem_busy_i, if_ready_i;

    logic        stall_a, flush_a, we_a, epc_we_a, bd_a, set_a, clr_a, busy_a;
    logic [31:0] new_pc_a, epc_a;
    logic [4:0]  code_a;
    logic        stall_b, flush_b, we_b, epc_we_b, bd_b, set_b, clr_b, busy_b;
    logic [31:0] new_pc_b, epc_b;
    logic [4:0]  code_b;

    out_t act_a, act_b;
    assign act_a = {stall_a, flush_a, new_pc_a, we_a, epc_we_a, code_a, epc_a, bd_a, set_a, clr_a, busy_a};
    assign act_b = {stall_b, flush_b, new_pc_b, we_b, epc_we_b, code_b, epc_b, bd_b, set_b, clr_b, busy_b};

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exc_flush_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .exc_type_i(exc_type_i), .mem_pc_i(mem_pc_i),
        .mem_in_delay_slot_i(mem_in_delay_slot_i), .cp0_status_i(cp0_status_i),
        .cp0_epc_i(cp0_epc_i), .dmem_busy_i(dmem_busy_i), .if_ready_i(if_ready_i),
        .stall_o(stall_a), .flush_o(flush_a), .new_pc_o(new_pc_a), .cp0_we_o(we_a),
        .cp0_epc_we_o(epc_we_a), .cp0_exc_code_o(code_a), .cp0_epc_o(epc_a),
        .cp0_bd_o(bd_a), .cp0_set_exl_o(set_a), .cp0_clr_exl_o(clr_a), .busy_o(busy_a)
    );

    exc_flush_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .exc_type_i(exc_type_i), .mem_pc_i(mem_pc_i),
        .mem_in_delay_slot_i(mem_in_delay_slot_i), .cp0_status_i(cp0_status_i),
        .cp0_epc_i(cp0_epc_i), .dmem_busy_i(dmem_busy_i), .if_ready_i(if_ready_i),
        .stall_o(stall_b), .flush_o(flush_b), .new_pc_o(new_pc_b), .cp0_we_o(we_b),
        .cp0_epc_we_o(epc_we_b), .cp0_exc_code_o(code_b), .cp0_epc_o(epc_b),
        .cp0_bd_o(bd_b), .cp0_set_exl_o(set_b), .cp0_clr_exl_o(clr_b), .busy_o(busy_b)
    );

    function automatic in_t mi(logic r, logic [31:0] e, logic [31:0] p, logic b,
                               logic [31:0] s, logic [31:0] ep, logic db, logic rd);
        return '{rst: r, exc: e, pc: p, bd: b, status: s, epc: ep, dbusy: db, rdy: rd};
    endfunction

    function automatic out_t mo(logic st, logic fl, logic [31:0] np, logic w, logic ew,
                                logic [4:0] c, logic [31:0] ep, logic b, logic se,
                                logic cl, logic bz);
        return '{stall: st, flush: fl, new_pc: np, we: w, epc_we: ew, code: c, epc: ep,
                 bd: b, set: se, clr: cl, busy: bz};
    endfunction

    task automatic drive(input in_t v);
        rst_i               = v.rst;
        exc_type_i          = v.exc;
        mem_pc_i            = v.pc;
        mem_in_delay_slot_i = v.bd;
        cp0_status_i        = v.status;
        cp0_epc_i           = v.epc;
        dmem_busy_i         = v.dbusy;
        if_ready_i          = v.rdy;
    endtask

    task automatic check(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t tbl[$];
    out_t z;

    initial begin
        z = mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Syscall, dmem idle
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), z});
        tbl.push_back('{mi(0, 32'h08, 32'h80001000, 0, 0, 0, 0, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), mo(1, 0, 0, 1, 1, 5'd8, 32'h80001000, 0, 1, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), mo(0, 1, VEC, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), z});
        // Overflow in delay slot, dmem busy for 3 cycles
        tbl.push_back('{mi(0, 32'h0c, 32'h80002004, 1, 0, 0, 1, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 1, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 1, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), mo(1, 0, 0, 1, 1, 5'd12, 32'h80002000, 1, 1, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0), mo(0, 1, VEC, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), mo(0, 1, VEC, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), z});
        // ERET: target is EPC sampled in the commit cycle
        tbl.push_back('{mi(0, 32'h0e, 32'h80004000, 0, 2, 32'h11111111, 0, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mi(0, 0, 0, 0, 2, 32'h80003000, 0, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 32'h22222222, 0, 1), mo(0, 1, 32'h80003000, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), z});
        // Interrupt with EXL already set: no EPC write; code arriving in FLUSH is ignored
        tbl.push_back('{mi(0, 32'h01, 32'h80005000, 0, 2, 0, 0, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mi(0, 0, 0, 0, 2, 0, 0, 1), mo(1, 0, 0, 1, 0, 5'd0, 0, 0, 1, 0, 1)});
        tbl.push_back('{mi(0, 32'h08, 32'h80006000, 0, 2, 0, 0, 1), mo(0, 1, VEC, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), z});
        // Illegal code 0x05
        tbl.push_back('{mi(0, 32'h05, 32'h80007000, 0, 0, 0, 0, 1), z});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), z});
        // Reset while draining
        tbl.push_back('{mi(0, 32'h09, 32'h80008000, 0, 0, 0, 1, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mi(1, 0, 0, 0, 0, 0, 1, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), z});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), z});
        // Reserved instruction in delay slot at PC 0: EPC wraps
        tbl.push_back('{mi(0, 32'h0a, 32'h00000000, 1, 0, 0, 0, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), mo(1, 0, 0, 1, 1, 5'd10, 32'hFFFFFFFC, 1, 1, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), mo(0, 1, VEC, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 1), z});

        drive(mi(1, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        foreach (tbl[k]) begin
            drive(tbl[k].i);
            #1;
            check($sformatf("vec%0d", k), act_a, tbl[k].o);
            @(negedge clk);
        end

        // Three-cycle flush with fetch not ready for five cycles
        drive(mi(1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mi(0, 32'h08, 32'h80009000, 0, 0, 0, 0, 0));
        #1;
        check("f3_accept", act_b, mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("f3_commit", act_b, mo(1, 0, 0, 1, 1, 5'd8, 32'h80009000, 0, 1, 0, 1));
        @(negedge clk);
        for (int f = 0; f < 6; f++) begin
            drive(mi(0, (f == 2) ? 32'h0c : 32'h0, 32'h8000A000, 0, 0, 0, 0, f == 5));
            #1;
            check($sformatf("f3_flush%0d", f), act_b, mo(0, 1, VEC, 0, 0, 0, 0, 0, 0, 0, 1));
            @(negedge clk);
        end
        drive(mi(0, 0, 0, 0, 0, 0, 0, 1));
        #1;
        check("f3_idle", act_b, z);
        @(negedge clk);
        #1;
        check("f3_idle2", act_b, z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exc_flush_ctrl.md
Name: exc_flush_ctrl

Overview:
- Sequences precise exception and ERET handling for the MIPS pipeline.
- Accepts the prioritised exception code from the mem stage and stalls the pipeline. It waits for any outstanding data-memory transaction to drain.
- It then issues one CP0 update pulse, flushes the pipeline, and redirects fetch to the exception vector or to EPC.
- Sits between the mem-stage exception encoder, CP0 and the hazard/fetch units.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry address
FLUSH_CYCLES, 1, minimum cycles flush_o stays high (legal 1..4)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
exc_type_i  input  32  encoded exception from mem stage; 0 = none
mem_pc_i  input  32  PC of the faulting mem-stage instruction
mem_in_delay_slot_i  input  1  faulting instruction is in a branch delay slot
cp0_status_i  input  32  current CP0 Status
cp0_epc_i  input  32  current CP0 EPC
dmem_busy_i  input  1  data-memory transaction outstanding
if_ready_i  input  1  fetch accepts the redirect this cycle
stall_o  output  1  hold all pipeline stages
flush_o  output  1  flush all pipeline stages
new_pc_o  output  32  redirect target; valid only while flush_o=1
cp0_we_o  output  1  one-cycle Cause/BD update strobe
cp0_epc_we_o  output  1  one-cycle EPC write strobe
cp0_exc_code_o  output  5  Cause.ExcCode value
cp0_epc_o  output  32  EPC write value
cp0_bd_o  output  1  Cause.BD value
cp0_set_exl_o  output  1  set Status.EXL (pulse)
cp0_clr_exl_o  output  1  clear Status.EXL (pulse, ERET)
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE. All outputs 0, including new_pc_o and cp0_epc_o. Reset in any state returns to IDLE next edge with no pending CP0 pulse or flush.
- Accepted codes and resulting ExcCode:
  - 0x01 interrupt -> 0
  - 0x08 syscall -> 8
  - 0x09 break -> 9
  - 0x0a reserved instruction -> 10
  - 0x0c overflow -> 12
  - 0x0d trap -> 13
  - 0x0e ERET -> no ExcCode
- Any other nonzero code is ignored: stays IDLE, no outputs asserted.
- IDLE:
  - On an accepted code, stall_o=1 combinationally in the same cycle.
  - At the clock edge, latch code, mem_pc_i and mem_in_delay_slot_i.
  - Next state: DRAIN if dmem_busy_i=1, else COMMIT.
- DRAIN:
  - stall_o=1; wait while dmem_busy_i=1, with no timeout.
  - Go to COMMIT in the cycle after dmem_busy_i is seen low.
- COMMIT (exactly 1 cycle, stall_o=1):
  - Exception:
    - cp0_we_o=1 with cp0_exc_code_o and cp0_bd_o = latched BD.
    - cp0_set_exl_o=1.
    - If cp0_status_i[1] (EXL)=0: cp0_epc_we_o=1 and cp0_epc_o = BD ? latched PC-4 : latched PC (32-bit wrap). Otherwise cp0_epc_we_o=0 (nested exception keeps the old EPC).
    - Target = EXC_VECTOR.
  - ERET:
    - cp0_clr_exl_o=1; cp0_we_o=0 and cp0_epc_we_o=0.
    - Target = cp0_epc_i sampled in this cycle.
  - Then go to FLUSH.
- FLUSH:
  - flush_o=1, stall_o=0, new_pc_o = registered target.
  - A counter loads FLUSH_CYCLES-1 on entry.
  - Exit to IDLE when counter=0 and if_ready_i=1; otherwise stay, holding new_pc_o stable.
  - All strobes are 0. exc_type_i is ignored, since the flushed stages produce no valid exceptions.
- busy_o=1 in DRAIN, COMMIT and FLUSH.
- All CP0 strobes are single-cycle. At most one exception is processed at a time. A code arriving while busy is ignored because the pipeline is stalled or flushed.
- Latency with dmem idle: accept at edge T, COMMIT cycle T+1, flush_o from T+2, earliest return to IDLE T+2+FLUSH_CYCLES.

Test Plan:
- Syscall 0x08, PC 0x80001000, BD=0, EXL=0, dmem idle -> cp0_we_o/epc_we_o pulse with ExcCode 8 and EPC 0x80001000 in cycle T+1; flush_o with new_pc_o 0xBFC00380 from T+2; IDLE after if_ready_i.
- Overflow 0x0c, BD=1, PC 0x80002004, dmem_busy_i high 3 cycles -> stall_o held through DRAIN; EPC 0x80002000, BD=1, ExcCode 12 written once.
- ERET 0x0e with cp0_epc_i=0x80003000 -> cp0_clr_exl_o pulse, no cp0_we_o; new_pc_o 0x80003000 during flush.
- Interrupt 0x01 with Status.EXL=1 -> cp0_we_o=1 (ExcCode 0), cp0_epc_we_o=0, new_pc_o 0xBFC00380.
- FLUSH_CYCLES=3 and if_ready_i low for 5 flush cycles -> flush_o held 6 cycles with stable new_pc_o; a second code during FLUSH is ignored.
- rst_i asserted in DRAIN; illegal code 0x05 in IDLE -> all outputs 0 the next cycle; 0x05 produces no stall.
